// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, PC-select encoding, fetch FSM states, IF/ID payload.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Matches the control unit's jumpAddr encoding.
  typedef enum logic [1:0] {
    PCSEL_NPC = 2'b00,
    PCSEL_J   = 2'b01,
    PCSEL_JR  = 2'b10,
    PCSEL_BR  = 2'b11
  } pcsel_t;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // One fetched instruction together with its pc+4.
  typedef struct packed {
    word_t instr;
    word_t npc;
  } ifid_t;

  // j/jal target: upper nibble of the jump's own pc+4, index shifted to words.
  function automatic word_t jump_target(input logic [3:0] npc_hi, input logic [25:0] idx);
    return {npc_hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's signals, with stage-side and bench-side views.
// Latency: n/a (wiring only).
// Backpressure: stall carries the hazard unit's freeze request.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  word_t       iload;
  logic        imemREN;
  word_t       imemaddr;
  logic        stall;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic [25:0] immJ;
  word_t       jr_target;
  word_t       br_target;
  logic        halt;
  word_t       ifid_instr;
  word_t       ifid_npc;
  logic        ifid_valid;

  modport fs (
    input  CLK, nRST, ihit, iload, stall, pc_sel, branch_taken, immJ,
           jr_target, br_target, halt,
    output imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
  );

  modport tb (
    output CLK, nRST, ihit, iload, stall, pc_sel, branch_taken, immJ,
           jr_target, br_target, halt,
    input  imemREN, imemaddr, ifid_instr, ifid_npc, ifid_valid
  );

endinterface

// File: rtl/fetch_stage_pc_target_mux.sv
// Decides whether decode is redirecting fetch and to which address.
// Latency: purely combinational.
// Backpressure: a redirect is suppressed while stall_i is high; it is re-presented later.
// Ports: stall_i, pc_sel_i, branch_taken_i, immJ_i, npc_hi_i (ifid_npc[31:28]),
//        jr_target_i, br_target_i -> redirect_o, target_o.
module pc_target_mux
  import cpu_types_pkg::*;
(
  input  logic        stall_i,
  input  logic [1:0]  pc_sel_i,
  input  logic        branch_taken_i,
  input  logic [25:0] immJ_i,
  input  logic [3:0]  npc_hi_i,
  input  word_t       jr_target_i,
  input  word_t       br_target_i,
  output logic        redirect_o,
  output word_t       target_o
);

  always_comb begin
    redirect_o = 1'b0;
    target_o   = '0;
    case (pcsel_t'(pc_sel_i))
      PCSEL_J: begin
        redirect_o = !stall_i;
        target_o   = jump_target(npc_hi_i, immJ_i);
      end
      PCSEL_JR: begin
        redirect_o = !stall_i;
        target_o   = jr_target_i;
      end
      PCSEL_BR: begin
        // An untaken branch is just sequential fetch.
        redirect_o = !stall_i && branch_taken_i;
        target_o   = br_target_i;
      end
      default: begin
        redirect_o = 1'b0;
        target_o   = '0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives imem requests, registers IF/ID.
// Latency: an instruction reaches IF/ID one edge after its ihit; 1 instr/cycle sustained.
// Backpressure: stall freezes IF/ID; one ihit during a stall parks in a hold buffer and REN drops.
// Ports: CLK/nRST; imem side ihit, iload, imemREN, imemaddr; decode side stall, pc_sel,
//        branch_taken, immJ, jr_target, br_target, halt; IF/ID outputs ifid_instr/npc/valid.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  word_t       iload,
  output logic        imemREN,
  output word_t       imemaddr,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic        branch_taken,
  input  logic [25:0] immJ,
  input  word_t       jr_target,
  input  word_t       br_target,
  input  logic        halt,
  output word_t       ifid_instr,
  output word_t       ifid_npc,
  output logic        ifid_valid
);

  fetch_state_t state_q;
  word_t        pc_q;
  ifid_t        ifid_q;
  logic         ifid_valid_q;
  ifid_t        hold_q;
  logic         hold_valid_q;
  logic         redir_pending_q;
  word_t        redir_pc_q;

  logic         redirect;
  word_t        target;
  word_t        pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32

  pc_target_mux u_pc_target_mux (
    .stall_i        (stall),
    .pc_sel_i       (pc_sel),
    .branch_taken_i (branch_taken),
    .immJ_i         (immJ),
    .npc_hi_i       (ifid_q.npc[31:28]),
    .jr_target_i    (jr_target),
    .br_target_i    (br_target),
    .redirect_o     (redirect),
    .target_o       (target)
  );

  // A full hold buffer means an instruction is already waiting; stop requesting.
  assign imemREN    = (state_q == FETCH) && !hold_valid_q;
  assign imemaddr   = pc_q;
  assign ifid_instr = ifid_q.instr;
  assign ifid_npc   = ifid_q.npc;
  assign ifid_valid = ifid_valid_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q         <= FETCH;
      pc_q            <= PC_INIT;
      ifid_q          <= '0;
      ifid_valid_q    <= 1'b0;
      hold_q          <= '0;
      hold_valid_q    <= 1'b0;
      redir_pending_q <= 1'b0;
      redir_pc_q      <= '0;
    end else if (state_q == FETCH) begin
      if (halt && !stall) begin
        state_q         <= HALTED;
        ifid_valid_q    <= 1'b0;
        hold_valid_q    <= 1'b0;
        redir_pending_q <= 1'b0;
      end else if (redirect) begin
        ifid_valid_q <= 1'b0;
        hold_valid_q <= 1'b0;
        if (ihit) begin
          pc_q            <= target;
          redir_pending_q <= 1'b0;
        end else begin
          // Keep imemaddr stable until the cache answers the outstanding request.
          redir_pending_q <= 1'b1;
          redir_pc_q      <= target;
        end
      end else if (redir_pending_q && ihit) begin
        // Word belongs to the wrong-path address; drop it and jump.
        pc_q            <= redir_pc_q;
        redir_pending_q <= 1'b0;
        ifid_valid_q    <= 1'b0;
      end else if (stall) begin
        if (ihit && !hold_valid_q) begin
          hold_q       <= '{instr: iload, npc: pc_plus4};
          hold_valid_q <= 1'b1;
          pc_q         <= pc_plus4;
        end
      end else if (hold_valid_q) begin
        ifid_q       <= hold_q;
        ifid_valid_q <= 1'b1;
        hold_valid_q <= 1'b0;
      end else if (ihit) begin
        ifid_q       <= '{instr: iload, npc: pc_plus4};
        ifid_valid_q <= 1'b1;
        pc_q         <= pc_plus4;
      end else begin
        ifid_valid_q <= 1'b0;
      end
    end else begin
      // HALTED: only reset leaves this state.
      ifid_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a queue-based reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_fetch_stage;
  import cpu_types_pkg::*;

  fetch_stage_if bus();

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK          (bus.CLK),
    .nRST         (bus.nRST),
    .ihit         (bus.ihit),
    .iload        (bus.iload),
    .imemREN      (bus.imemREN),
    .imemaddr     (bus.imemaddr),
    .stall        (bus.stall),
    .pc_sel       (bus.pc_sel),
    .branch_taken (bus.branch_taken),
    .immJ         (bus.immJ),
    .jr_target    (bus.jr_target),
    .br_target    (bus.br_target),
    .halt         (bus.halt),
    .ifid_instr   (bus.ifid_instr),
    .ifid_npc     (bus.ifid_npc),
    .ifid_valid   (bus.ifid_valid)
  );

  initial bus.CLK = 1'b0;
  always #5 bus.CLK = ~bus.CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  word_t m_pc;
  logic  m_halted;
  word_t m_instr;
  word_t m_npc;
  logic  m_valid;
  ifid_t hold_fifo[$];   // at most one parked instruction
  word_t pend_fifo[$];   // at most one deferred redirect target

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_ren();
    return !m_halted && (hold_fifo.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_halted = 1'b0;
    m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
    hold_fifo.delete(); pend_fifo.delete();
  endtask

  task automatic model_step();
    logic  redir;
    word_t tgt;
    ifid_t e;
    if (m_halted) return;
    redir = 1'b0; tgt = 32'h0;
    if (!bus.stall) begin
      if (bus.pc_sel == 2'd1) begin redir = 1'b1; tgt = {m_npc[31:28], bus.immJ, 2'b00}; end
      if (bus.pc_sel == 2'd2) begin redir = 1'b1; tgt = bus.jr_target; end
      if (bus.pc_sel == 2'd3 && bus.branch_taken) begin redir = 1'b1; tgt = bus.br_target; end
    end
    if (bus.halt && !bus.stall) begin
      m_halted = 1'b1; m_valid = 1'b0;
      hold_fifo.delete(); pend_fifo.delete();
    end else if (redir) begin
      m_valid = 1'b0;
      hold_fifo.delete(); pend_fifo.delete();
      if (bus.ihit) m_pc = tgt;
      else pend_fifo.push_back(tgt);
    end else if (pend_fifo.size() != 0 && bus.ihit) begin
      m_pc = pend_fifo.pop_front();
      m_valid = 1'b0;
    end else if (bus.stall) begin
      if (bus.ihit && hold_fifo.size() == 0) begin
        e.instr = bus.iload; e.npc = m_pc + 32'd4;
        hold_fifo.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end else if (hold_fifo.size() != 0) begin
      e = hold_fifo.pop_front();
      m_instr = e.instr; m_npc = e.npc; m_valid = 1'b1;
    end else if (bus.ihit) begin
      m_instr = bus.iload; m_npc = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_model();
    chk("model_imemREN",    {31'b0, bus.imemREN},    {31'b0, m_ren()});
    chk("model_imemaddr",   bus.imemaddr,            m_pc);
    chk("model_ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, m_valid});
    chk("model_ifid_instr", bus.ifid_instr,          m_instr);
    chk("model_ifid_npc",   bus.ifid_npc,            m_npc);
  endtask

  task automatic cycle();
    @(posedge bus.CLK);
    if (bus.nRST) model_step();
    @(negedge bus.CLK);
    compare_model();
  endtask

  task automatic drive(input logic ih, input word_t ld, input logic st, input logic [1:0] sel,
                       input logic bt, input logic hl);
    bus.ihit = ih; bus.iload = ld; bus.stall = st; bus.pc_sel = sel;
    bus.branch_taken = bt; bus.halt = hl;
  endtask

  initial begin
    bus.nRST = 1'b0;
    bus.immJ = 26'h0; bus.jr_target = 32'h0; bus.br_target = 32'h0;
    drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    model_reset();
    @(negedge bus.CLK);
    @(negedge bus.CLK);
    compare_model();
    chk("rst_addr",  bus.imemaddr, 32'h0);
    chk("rst_ren",   {31'b0, bus.imemREN}, 32'd1);
    chk("rst_valid", {31'b0, bus.ifid_valid}, 32'd0);
    chk("rst_instr", bus.ifid_instr, 32'h0);
    bus.nRST = 1'b1;

    // Sequential fetch A, B
    drive(1'b1, 32'hAAAA_0001, 1'b0, 2'd0, 1'b0, 1'b0); cycle();
    chk("seqA_instr", bus.ifid_instr, 32'hAAAA_0001);
    chk("seqA_npc",   bus.ifid_npc,   32'h4);
    chk("seqA_valid", {31'b0, bus.ifid_valid}, 32'd1);
    drive(1'b1, 32'hBBBB_0002, 1'b0, 2'd0, 1'b0, 1'b0); cycle();
    chk("seqB_npc",  bus.ifid_npc,  32'h8);
    chk("seqB_addr", bus.imemaddr,  32'h8);

    // Stall with ihit: C parks in the hold buffer
    drive(1'b1, 32'hCCCC_0003, 1'b1, 2'd0, 1'b0, 1'b0); cycle();
    chk("stall_hold_instr", bus.ifid_instr, 32'hBBBB_0002);
    chk("stall_ren",        {31'b0, bus.imemREN}, 32'd0);
    chk("stall_addr",       bus.imemaddr, 32'hC);
    drive(1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0); cycle(); cycle();
    drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0); cycle();
    chk("unstall_instr", bus.ifid_instr, 32'hCCCC_0003);
    chk("unstall_npc",   bus.ifid_npc,   32'hC);
    chk("unstall_ren",   {31'b0, bus.imemREN}, 32'd1);
    drive(1'b1, 32'hDDDD_0004, 1'b0, 2'd0, 1'b0, 1'b0); cycle();
    chk("resume_npc", bus.ifid_npc, 32'h10);

    // jr with ihit -> 0x1000_0000, then fetch E to get npc 0x1000_0004
    bus.jr_target = 32'h1000_0000;
    drive(1'b1, 32'h0BAD_0BAD, 1'b0, 2'd2, 1'b0, 1'b0); cycle();
    chk("jr_hit_valid", {31'b0, bus.ifid_valid}, 32'd0);
    chk("jr_hit_addr",  bus.imemaddr, 32'h1000_0000);
    drive(1'b1, 32'hEEEE_0005, 1'b0, 2'd0, 1'b0, 1'b0); cycle();
    chk("E_npc", bus.ifid_npc, 32'h1000_0004);

    // j: {0x1, 0x40, 00}
    bus.immJ = 26'h000_0040;
    drive(1'b1, 32'h0BAD_0BAD, 1'b0, 2'd1, 1'b0, 1'b0); cycle();
    chk("j_valid", {31'b0, bus.ifid_valid}, 32'd0);
    chk("j_addr",  bus.imemaddr, 32'h1000_0100);

    // jr without ihit: deferred
    bus.jr_target = 32'h200;
    drive(1'b0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0); cycle();
    chk("jr_miss_addr", bus.imemaddr, 32'h1000_0100);
    drive(1'b1, 32'hFFFF_0006, 1'b0, 2'd0, 1'b0, 1'b0); cycle();
    chk("jr_late_addr",  bus.imemaddr, 32'h200);
    chk("jr_late_valid", {31'b0, bus.ifid_valid}, 32'd0);
    chk("jr_late_instr", bus.ifid_instr, 32'hEEEE_0005);

    // Untaken branch falls through
    bus.br_target = 32'h40;
    drive(1'b1, 32'h6666_0007, 1'b0, 2'd3, 1'b0, 1'b0); cycle();
    chk("bnt_instr", bus.ifid_instr, 32'h6666_0007);
    chk("bnt_npc",   bus.ifid_npc,   32'h204);
    // Taken branch under stall is ignored, then taken once stall drops
    drive(1'b0, 32'h0, 1'b1, 2'd3, 1'b1, 1'b0); cycle();
    chk("br_stall_addr", bus.imemaddr, 32'h204);
    drive(1'b1, 32'h0BAD_0BAD, 1'b0, 2'd3, 1'b1, 1'b0); cycle();
    chk("br_addr",  bus.imemaddr, 32'h40);
    chk("br_valid", {31'b0, bus.ifid_valid}, 32'd0);

    // pc wraps from 0xFFFF_FFFC to 0
    bus.jr_target = 32'hFFFF_FFFC;
    drive(1'b1, 32'h0BAD_0BAD, 1'b0, 2'd2, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h7777_0008, 1'b0, 2'd0, 1'b0, 1'b0); cycle();
    chk("wrap_npc",  bus.ifid_npc, 32'h0);
    chk("wrap_addr", bus.imemaddr, 32'h0);
    drive(1'b1, 32'h8888_0009, 1'b0, 2'd0, 1'b0, 1'b0); cycle();
    chk("post_wrap_npc", bus.ifid_npc, 32'h4);

    // Halt, ihit afterwards ignored
    drive(1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1); cycle();
    chk("halt_ren",   {31'b0, bus.imemREN}, 32'd0);
    chk("halt_valid", {31'b0, bus.ifid_valid}, 32'd0);
    drive(1'b1, 32'h9999_000A, 1'b0, 2'd0, 1'b0, 1'b0);
    repeat (3) cycle();
    chk("halted_ren",  {31'b0, bus.imemREN}, 32'd0);
    chk("halted_addr", bus.imemaddr, 32'h4);

    // Asynchronous reset between edges
    #2 bus.nRST = 1'b0;
    model_reset();
    #1;
    chk("arst_addr",  bus.imemaddr, 32'h0);
    chk("arst_instr", bus.ifid_instr, 32'h0);
    chk("arst_npc",   bus.ifid_npc, 32'h0);
    chk("arst_ren",   {31'b0, bus.imemREN}, 32'd1);
    cycle();
    bus.nRST = 1'b1;

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      if (!bus.nRST) begin
        bus.nRST = 1'b1;
      end else if (($urandom % 400 == 0) || (m_halted && ($urandom % 20 == 0))) begin
        bus.nRST = 1'b0;
        model_reset();
        #1 compare_model();
      end
      bus.stall        = ($urandom % 4 == 0);
      bus.pc_sel       = ($urandom % 3 == 0) ? 2'($urandom % 4) : 2'd0;
      bus.branch_taken = $urandom % 2;
      bus.halt         = ($urandom % 150 == 0);
      bus.ihit         = m_ren() && ($urandom % 4 != 0);
      bus.iload        = $urandom;
      bus.immJ         = 26'($urandom);
      bus.jr_target    = ($urandom % 8 == 0) ? 32'hFFFF_FFF8 : $urandom;
      bus.br_target    = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
